add_rc: RTL and testbench
=========================

// Module: add_rc
// PURPOSE
//   N-bit ripple-carry adder with carry-in and carry-out, built from a chain of
//   1-bit full-adder cells. Sum/carry are combinational; registered copies are
//   provided for clocked consumers.
//   Used as the arithmetic core of the perimeter datapath, e.g. a+b ahead of
//   the x2 shift. The controller samples the combinational result one clock
//   after the operands are loaded.
// PARAMETERS
//   N   default 4   operand/sum width in bits (N >= 1)
// PORTS
//   clock     in   1   system clock, rising-edge
//   reset_    in   1   asynchronous, active-low reset
//   x         in   N   operand X, unsigned
//   y         in   N   operand Y, unsigned
//   c_in      in   1   carry into bit 0
//   s         out  N   combinational sum (x + y + c_in) mod 2^N
//   c_out     out  1   combinational carry out of bit N-1
//   s_r       out  N   s registered on the rising edge of clock
//   c_out_r   out  1   c_out registered on the rising edge of clock
// BEHAVIOUR
//   - Combinational path: {c_out, s} = x + y + c_in, exact (N+1)-bit unsigned result.
//     - No latency; no dependence on clock or reset_.
//     - Must be correct for every x, y in [0, 2^N-1] and c_in in {0,1}.
//   - Ripple structure: carry[0] = c_in; for each bit i:
//     - s[i] = x[i] ^ y[i] ^ carry[i]
//     - carry[i+1] = x[i]&y[i] | carry[i]&(x[i]^y[i])
//     - c_out = carry[N].
//   - Registered path: on each posedge clock with reset_ = 1, s_r <= s and c_out_r <= c_out.
//     - Latency 1 cycle; no enable, updates every cycle.
//   - Reset: reset_ = 0 immediately forces s_r = 0 and c_out_r = 0, without waiting
//     for a clock edge.
//     - Registers hold 0 while reset_ is low.
//     - First capture happens at the first posedge after reset_ rises.
//     - The combinational outputs stay live during reset.
//   - Overflow boundaries:
//     - Wrap-around when x + y + c_in >= 2^N: s holds the low N bits, c_out = 1.
//     - Maximum case x = y = 2^N-1 with c_in = 1 gives s = 2^N-1, c_out = 1.
//   - Operands changing at the same time as a clock edge: the register captures the
//     value settled before the edge (normal setup rules). No internal state beyond
//     the two output registers.
//   - No X-propagation tricks: an unknown input bit may only corrupt the sum bits
//     at and above it.
// STRUCTURE
//   - Sub-module fa_cell (a, b, ci -> s, co): 1-bit full adder.
//     - Instantiated N times in a generate loop, chained through the internal
//       carry[N:0] wire.
//   - Output registers live in add_rc itself: one always block sensitive to
//     posedge clock and negedge reset_.
//   - No shared package needed; the only constant is the default N = 4, kept as
//     the module parameter.
// TESTING
//   - N=4, x=3, y=5, c_in=0 -> s=8, c_out=0; one clock later s_r=8, c_out_r=0.
//   - N=4, x=15, y=1, c_in=0 -> s=0, c_out=1 (wrap).
//   - N=4, x=15, y=15, c_in=1 -> s=15, c_out=1.
//   - N=4, x=9, y=9, c_in=0 -> s=2, c_out=1.
//     - Perimeter use: x=5, y=6 -> s=11, so perimeter {s,1'b0} = 22.
//   - Reset mid-operation:
//     - With s_r=8, drop reset_ between clock edges -> s_r=0, c_out_r=0 at once.
//     - s keeps tracking x+y.
//     - Release reset_ -> s_r takes the current sum at the next posedge.
//   - Exhaustive sweep for N=4 (all x, y, c_in) plus random checks for N=8 and N=1:
//     - compare {c_out, s} to x+y+c_in;
//     - compare {c_out_r, s_r} to the previous cycle's value.

Source files
------------

// File: rtl/fa_cell.sv
// fa_cell: 1-bit full adder, the repeating stage of the ripple-carry chain
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/add_rc.sv
// add_rc: N-bit ripple-carry adder with combinational and registered sum/carry outputs
module add_rc #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic [N-1:0] s_r,
  output logic         c_out_r
);
  logic [N:0]   carry;
  logic [N-1:0] s_d, s_q;
  logic         c_d, c_q;
  assign carry[0] = c_in;
  for (genvar i = 0; i < N; i++) begin : g_bit
    fa_cell u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end
  assign c_out   = carry[N];
  assign s_d     = s;
  assign c_d     = carry[N];
  assign s_r     = s_q;
  assign c_out_r = c_q;
  // capture the settled sum every edge; reset clears the copies immediately
  always_ff @(posedge clock or negedge reset_)
    if (!reset_) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
endmodule

// File: tb/tb_add_rc.sv
// tb_add_rc: scoreboard bench for add_rc at N=4 (directed + exhaustive), N=8 and N=1 (random)
module tb_add_rc;
  logic       clock = 1'b0;
  logic       reset_ = 1'b0;
  logic [3:0] x4 = '0, y4 = '0, s4, sr4;
  logic       c4 = 1'b0, co4, cor4;
  logic [7:0] x8 = '0, y8 = '0, s8, sr8;
  logic       c8 = 1'b0, co8, cor8;
  logic [0:0] x1 = '0, y1 = '0, s1, sr1;
  logic       c1 = 1'b0, co1, cor1;
  logic [4:0] q4[$];
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  add_rc #(.N(4)) u4 (.clock(clock), .reset_(reset_), .x(x4), .y(y4), .c_in(c4),
                      .s(s4), .c_out(co4), .s_r(sr4), .c_out_r(cor4));
  add_rc #(.N(8)) u8 (.clock(clock), .reset_(reset_), .x(x8), .y(y8), .c_in(c8),
                      .s(s8), .c_out(co8), .s_r(sr8), .c_out_r(cor8));
  add_rc #(.N(1)) u1 (.clock(clock), .reset_(reset_), .x(x1), .y(y1), .c_in(c1),
                      .s(s1), .c_out(co1), .s_r(sr1), .c_out_r(cor1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] a4, input logic [3:0] b4, input logic ci4);
    logic [4:0] e4;
    logic [8:0] e8;
    logic [1:0] e1;
    @(negedge clock);
    x4 = a4; y4 = b4; c4 = ci4;
    x8 = 8'($urandom); y8 = 8'($urandom); c8 = 1'($urandom);
    x1 = 1'($urandom); y1 = 1'($urandom); c1 = 1'($urandom);
    e4 = 5'(a4) + 5'(b4) + 5'(ci4);
    e8 = 9'(x8) + 9'(y8) + 9'(c8);
    e1 = 2'(x1) + 2'(y1) + 2'(c1);
    #1;
    chk("comb4", {co4, s4}, e4);
    chk("comb8", {co8, s8}, e8);
    chk("comb1", {co1, s1}, e1);
    q4.push_back(e4);
    q8.push_back(e8);
    q1.push_back(e1);
    @(posedge clock);
    #1;
    if (q4.size() == 0) chk("q4_empty", 0, 1); else chk("reg4", {cor4, sr4}, q4.pop_front());
    if (q8.size() == 0) chk("q8_empty", 0, 1); else chk("reg8", {cor8, sr8}, q8.pop_front());
    if (q1.size() == 0) chk("q1_empty", 0, 1); else chk("reg1", {cor1, sr1}, q1.pop_front());
  endtask

  initial begin
    #2;
    chk("rst_sr4", {cor4, sr4}, 0);
    @(posedge clock);
    #1;
    chk("rst_hold4", {cor4, sr4}, 0);
    chk("rst_hold8", {cor8, sr8}, 0);
    @(negedge clock);
    reset_ = 1'b1;
    step(4'd15, 4'd1, 1'b0);
    chk("wrap", {co4, s4}, 5'h10);
    step(4'd15, 4'd15, 1'b1);
    chk("max", {co4, s4}, 5'h1f);
    step(4'd9, 4'd9, 1'b0);
    chk("nine", {co4, s4}, 5'h12);
    step(4'd5, 4'd6, 1'b0);
    chk("perim", {s4, 1'b0}, 22);
    step(4'd3, 4'd5, 1'b0);
    chk("pre_rst_sr", {cor4, sr4}, 8);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async_sr", {cor4, sr4}, 0);
    chk("async_sr8", {cor8, sr8}, 0);
    chk("live_s", {co4, s4}, 8);
    x4 = 4'd4;
    #1;
    chk("live_s2", {co4, s4}, 9);
    @(posedge clock);
    #1;
    chk("rst_held", {cor4, sr4}, 0);
    @(negedge clock);
    reset_ = 1'b1;
    #1;
    chk("rel_wait", {cor4, sr4}, 0);
    @(posedge clock);
    #1;
    chk("rel_cap", {cor4, sr4}, 9);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          step(4'(a), 4'(b), 1'(c));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
